// File: rtl/softmax_sched_pkg.sv
// softmax_sched_pkg: shared constants for the softmax job sequencer.
// Holds the FSM state encodings and the completion error codes
// returned on cpl_err.
package softmax_sched_pkg;

  // Sequencer FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_CPL   = 3'd5;

  // Completion error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/sched_cmd_fifo.sv
// sched_cmd_fifo: synchronous command FIFO, DEPTH entries of W bits.
// Ports: push/push_data write, pop/pop_data read (head always visible, no
// bypass), full/empty derived from a registered occupancy count.
module sched_cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/softmax_job_sched.sv
// softmax_job_sched: queues softmax job descriptors and launches them one at
// a time on a single softmax core, with a per-job watchdog.
// Ports: cmd_* descriptor input (valid/ready), core_* control/address to the
// core, cpl_* tagged completion output (valid/ready), busy and jobs_ok status.
module softmax_job_sched
  import softmax_sched_pkg::*;
#(
  parameter int ADDRSIZE = 8,
  parameter int TAGW     = 4,
  parameter int QDEPTH   = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDRSIZE-1:0] cmd_start_addr,
  input  logic [ADDRSIZE-1:0] cmd_end_addr,
  input  logic [TAGW-1:0]     cmd_tag,
  output logic                core_init,
  output logic                core_start,
  output logic                core_reset,
  output logic [ADDRSIZE-1:0] core_start_addr,
  output logic [ADDRSIZE-1:0] core_end_addr,
  input  logic                core_done,
  output logic                cpl_valid,
  input  logic                cpl_ready,
  output logic [TAGW-1:0]     cpl_tag,
  output logic [1:0]          cpl_err,
  output logic                busy,
  output logic [15:0]         jobs_ok
);

  localparam int DW  = 2 * ADDRSIZE + TAGW;
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [2:0]          state;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [DW-1:0]       head;
  logic [ADDRSIZE-1:0] head_start;
  logic [ADDRSIZE-1:0] head_end;
  logic [TAGW-1:0]     head_tag;
  logic                done_q;
  logic                done_rise;
  logic [WDW-1:0]      wdog;
  logic                wdog_exp;
  logic                core_reset_q;

  // cmd_ready follows the registered count only, so a pop in this cycle
  // does not open a slot until the next one.
  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;

  sched_cmd_fifo #(
    .W     (DW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cmd_start_addr, cmd_end_addr, cmd_tag}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_start, head_end, head_tag} = head;

  // The core's done is a level that may linger; only its rising edge ends RUN.
  assign done_rise = core_done & ~done_q;
  assign wdog_exp  = (wdog == WDW'(TIMEOUT - 1));

  assign core_init  = (state == ST_INIT);
  assign core_start = (state == ST_START);
  assign cpl_valid  = (state == ST_CPL);
  assign busy       = (state != ST_IDLE) | ~fifo_empty;
  // Reset reaches the core immediately; a watchdog abort adds a one-cycle pulse.
  assign core_reset = reset | core_reset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      core_start_addr <= '0;
      core_end_addr   <= '0;
      cpl_tag         <= '0;
      cpl_err         <= ERR_OK;
      jobs_ok         <= '0;
      done_q          <= 1'b0;
      wdog            <= '0;
      core_reset_q    <= 1'b1;
    end else begin
      done_q       <= core_done;
      core_reset_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            core_start_addr <= head_start;
            core_end_addr   <= head_end;
            cpl_tag         <= head_tag;
            // Empty or inverted ranges never reach the core.
            if (head_start >= head_end) begin
              cpl_err <= ERR_RANGE;
              state   <= ST_CPL;
            end else begin
              cpl_err <= ERR_OK;
              state   <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          state <= ST_START;
        end
        ST_START: begin
          wdog  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (done_rise) begin
            state <= ST_DRAIN;
          end else if (wdog_exp) begin
            core_reset_q <= 1'b1;
            cpl_err      <= ERR_TIMEOUT;
            state        <= ST_CPL;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Wait for done to drop so the next job sees a clean edge.
          if (!core_done) state <= ST_CPL;
        end
        ST_CPL: begin
          if (cpl_ready) begin
            if (cpl_err == ERR_OK) jobs_ok <= jobs_ok + 16'd1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_job_sched.sv
// tb_softmax_job_sched: directed bench for softmax_job_sched with a small
// behavioural core model (done high for 3 cycles, DLY cycles after start).
// Ports: none; drives the DUT and prints one summary line.
module tb_softmax_job_sched;

  localparam int TO  = 64;
  localparam int DLY = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start_addr;
  logic [7:0] cmd_end_addr;
  logic [3:0] cmd_tag;
  logic       core_init;
  logic       core_start;
  logic       core_reset;
  logic [7:0] core_start_addr;
  logic [7:0] core_end_addr;
  logic       core_done;
  logic       cpl_valid;
  logic       cpl_ready;
  logic [3:0] cpl_tag;
  logic [1:0] cpl_err;
  logic       busy;
  logic [15:0] jobs_ok;

  int n_vec = 0;
  int n_err = 0;
  int init_cnt = 0;
  int start_cnt = 0;

  logic model_en;
  logic core_busy;
  int   core_cnt;

  always #5 clk = ~clk;

  softmax_job_sched #(
    .ADDRSIZE (8),
    .TAGW     (4),
    .QDEPTH   (4),
    .TIMEOUT  (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_start_addr  (cmd_start_addr),
    .cmd_end_addr    (cmd_end_addr),
    .cmd_tag         (cmd_tag),
    .core_init       (core_init),
    .core_start      (core_start),
    .core_reset      (core_reset),
    .core_start_addr (core_start_addr),
    .core_end_addr   (core_end_addr),
    .core_done       (core_done),
    .cpl_valid       (cpl_valid),
    .cpl_ready       (cpl_ready),
    .cpl_tag         (cpl_tag),
    .cpl_err         (cpl_err),
    .busy            (busy),
    .jobs_ok         (jobs_ok)
  );

  // Core model: after a start pulse, done rises DLY cycles later for 3 cycles.
  always @(posedge clk) begin
    if (core_reset) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else if (core_busy) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == DLY - 1) core_done <= 1'b1;
      if (core_cnt == DLY + 2) begin
        core_done <= 1'b0;
        core_busy <= 1'b0;
      end
    end else if (core_start && model_en) begin
      core_busy <= 1'b1;
      core_cnt  <= 0;
    end
  end

  always @(posedge clk) begin
    if (core_init)  init_cnt++;
    if (core_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] e, input logic [3:0] t);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_start_addr = s;
    cmd_end_addr = e;
    cmd_tag = t;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cpl(output int n);
    n = 0;
    while (!cpl_valid && n < 300) begin
      tick();
      n++;
    end
    chk("cpl_seen", cpl_valid, 1);
  endtask

  task automatic handshake();
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    int i0;
    int s0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_start_addr = '0;
    cmd_end_addr = '0;
    cmd_tag = '0;
    cpl_ready = 1'b0;
    model_en = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_jobs_ok", jobs_ok, 0);
    chk("rst_cpl_err", cpl_err, 0);
    chk("rst_start_addr", core_start_addr, 0);
    reset = 1'b0;
    tick();
    tick();

    // Single job: accept at edge 0, init in cycle 2, start in cycle 3
    push(8'd0, 8'd8, 4'd3);
    chk("a_busy_c1", busy, 1);
    chk("a_init_c1", core_init, 0);
    tick();
    chk("a_init_c2", core_init, 1);
    chk("a_saddr", core_start_addr, 0);
    chk("a_eaddr", core_end_addr, 8);
    tick();
    chk("a_start_c3", core_start, 1);
    chk("a_init_c3", core_init, 0);
    n = 3;
    while (!cpl_valid && n < 300) begin
      tick();
      n++;
    end
    // done high in cycle 4+DLY, low from 4+DLY+3, CPL one cycle later
    chk("a_cpl_cycle", n, 4 + DLY + 4);
    chk("a_tag", cpl_tag, 3);
    chk("a_err", cpl_err, 0);
    chk("a_jobs_ok_pre", jobs_ok, 0);
    handshake();
    chk("a_jobs_ok", jobs_ok, 1);
    chk("a_cpl_drop", cpl_valid, 0);
    tick();

    // Bad range, then fill the FIFO while the completion is held
    i0 = init_cnt;
    s0 = start_cnt;
    push(8'd5, 8'd5, 4'd9);
    chk("b_cpl_c1", cpl_valid, 0);
    tick();
    chk("b_cpl_c2", cpl_valid, 1);
    chk("b_err", cpl_err, 1);
    chk("b_tag", cpl_tag, 9);
    for (int i = 0; i < 4; i++) push(8'(i * 16), 8'(i * 16 + 8), 4'(i + 1));
    cmd_valid = 1'b1;
    cmd_start_addr = 8'd64;
    cmd_end_addr = 8'd72;
    cmd_tag = 4'd5;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready !== 1'b0 || cpl_valid !== 1'b1 || cpl_tag !== 4'd9 || cpl_err !== 2'd1) bad++;
      tick();
    end
    chk("f_stable", bad, 0);
    chk("f_no_init", init_cnt - i0, 0);
    chk("f_no_start", start_cnt - s0, 0);
    handshake();
    chk("c_ready_hs1", cmd_ready, 0);
    chk("c_cpl_drop", cpl_valid, 0);
    tick();
    chk("c_ready_hs2", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_cpl(n);
      chk("c_tag", cpl_tag, j + 1);
      chk("c_err", cpl_err, 0);
      chk("c_saddr", core_start_addr, j * 16);
      handshake();
    end
    chk("c_jobs_ok", jobs_ok, 6);

    // Watchdog abort with a silent core
    tick();
    model_en = 1'b0;
    push(8'd0, 8'd4, 4'd7);
    n = 0;
    while (!core_start && n < 20) begin
      tick();
      n++;
    end
    chk("d_start_seen", core_start, 1);
    tick();
    n = 1;
    bad = 0;
    while (!cpl_valid && n < 200) begin
      if (core_reset !== 1'b0) bad++;
      tick();
      n++;
    end
    chk("d_run_len", n, TO + 1);
    chk("d_no_early_rst", bad, 0);
    chk("d_core_reset", core_reset, 1);
    chk("d_err", cpl_err, 2);
    chk("d_tag", cpl_tag, 7);
    tick();
    chk("d_rst_1cyc", core_reset, 0);
    chk("d_cpl_hold", cpl_valid, 1);
    handshake();
    chk("d_jobs_ok", jobs_ok, 6);
    model_en = 1'b1;
    push(8'd2, 8'd10, 4'd8);
    wait_cpl(n);
    chk("d_next_tag", cpl_tag, 8);
    chk("d_next_err", cpl_err, 0);
    handshake();
    chk("d_next_jobs_ok", jobs_ok, 7);

    // Reset during RUN with two jobs queued
    tick();
    push(8'd2, 8'd6, 4'd1);
    push(8'd3, 8'd7, 4'd2);
    push(8'd4, 8'd8, 4'd4);
    n = 0;
    while (!core_start && n < 20) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk("e_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("e_core_reset", core_reset, 1);
    chk("e_cpl_valid_r", cpl_valid, 0);
    chk("e_cmd_ready_r", cmd_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    chk("e_busy", busy, 0);
    chk("e_cmd_ready", cmd_ready, 1);
    chk("e_cpl_valid", cpl_valid, 0);
    chk("e_jobs_ok", jobs_ok, 0);
    i0 = init_cnt;
    repeat (8) tick();
    chk("e_no_launch", init_cnt - i0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
